// File: rtl/button_event_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : button_event_pkg
//  Description : Shared types and sizing helper for the button event decoder.
//  Revision    : 1.0 - initial release
// ============================================================================
package button_event_pkg;

    typedef enum logic [1:0] {
        LOCK    = 2'd0,
        IDLE    = 2'd1,
        PRESSED = 2'd2,
        REPEAT  = 2'd3
    } btn_state_t;

    // Hold counter must be able to represent the larger terminal value.
    function automatic int count_width(input int long_cycles, input int repeat_cycles);
        int max_c;
        max_c = (long_cycles > repeat_cycles) ? long_cycles : repeat_cycles;
        return $clog2(max_c + 1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/button_event.sv
`default_nettype none
// ============================================================================
//  Module      : button_event
//  Description : Turns a debounced button level into press / release /
//                long-press / auto-repeat single-cycle pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module button_event
    import button_event_pkg::*;
#(
    parameter int LONG_PRESS_CYCLES = 12_000_000,
    parameter int REPEAT_CYCLES     = 3_000_000
) (
    input  logic i_Clk,
    input  logic i_Rst,
    input  logic i_Data,
    output logic o_Press,
    output logic o_Release,
    output logic o_Long,
    output logic o_Repeat,
    output logic o_Step,
    output logic o_Held
);

    localparam int                 c_cnt_w  = count_width(LONG_PRESS_CYCLES, REPEAT_CYCLES);
    localparam logic [c_cnt_w-1:0] c_long   = c_cnt_w'(LONG_PRESS_CYCLES);
    localparam logic [c_cnt_w-1:0] c_repeat = c_cnt_w'(REPEAT_CYCLES);
    localparam logic [c_cnt_w-1:0] c_one    = c_cnt_w'(1);

    btn_state_t         r_state;
    logic [c_cnt_w-1:0] r_count;
    logic               r_press;
    logic               r_release;
    logic               r_long;
    logic               r_repeat;
    logic               r_step;
    logic               r_held;

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_state   <= LOCK;
            r_count   <= '0;
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_long    <= 1'b0;
            r_repeat  <= 1'b0;
            r_step    <= 1'b0;
            r_held    <= 1'b0;
        end else begin
            r_press   <= 1'b0;
            r_release <= 1'b0;
            r_long    <= 1'b0;
            r_repeat  <= 1'b0;
            r_step    <= 1'b0;

            case (r_state)
                // A button still held out of reset must be let go before it counts.
                LOCK: begin
                    r_held  <= 1'b0;
                    r_count <= '0;
                    if (!i_Data) begin
                        r_state <= IDLE;
                    end
                end

                IDLE: begin
                    if (i_Data) begin
                        r_state <= PRESSED;
                        r_count <= c_one;
                        r_press <= 1'b1;
                        r_step  <= 1'b1;
                        r_held  <= 1'b1;
                    end
                end

                PRESSED: begin
                    if (!i_Data) begin
                        r_state   <= IDLE;
                        r_count   <= '0;
                        r_release <= 1'b1;
                        r_held    <= 1'b0;
                    end else if (r_count == c_long) begin
                        r_state <= REPEAT;
                        r_count <= c_one;
                        r_long  <= 1'b1;
                        r_step  <= 1'b1;
                    end else begin
                        r_count <= r_count + c_one;
                    end
                end

                REPEAT: begin
                    if (!i_Data) begin
                        r_state   <= IDLE;
                        r_count   <= '0;
                        r_release <= 1'b1;
                        r_held    <= 1'b0;
                    end else if (r_count == c_repeat) begin
                        r_count  <= c_one;
                        r_repeat <= 1'b1;
                        r_step   <= 1'b1;
                    end else begin
                        r_count <= r_count + c_one;
                    end
                end

                default: begin
                    r_state <= LOCK;
                    r_count <= '0;
                    r_held  <= 1'b0;
                end
            endcase
        end
    end

    assign o_Press   = r_press;
    assign o_Release = r_release;
    assign o_Long    = r_long;
    assign o_Repeat  = r_repeat;
    assign o_Step    = r_step;
    assign o_Held    = r_held;

`ifndef SYNTHESIS
    generate
        if (LONG_PRESS_CYCLES < 2) begin : g_bad_long
            $error("button_event: LONG_PRESS_CYCLES must be >= 2");
        end
        if (REPEAT_CYCLES < 1) begin : g_bad_repeat
            $error("button_event: REPEAT_CYCLES must be >= 1");
        end
    endgenerate

    always_ff @(posedge i_Clk) begin
        assert ($onehot0({r_press, r_release, r_long, r_repeat}))
            else $error("button_event: event pulses overlap");
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_button_event.sv
`default_nettype none
// ============================================================================
//  Module      : tb_button_event
//  Description : Directed + randomized bench for button_event against a
//                timeline-based reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_button_event;

    localparam int c_long   = 8;
    localparam int c_repeat = 3;

    logic i_Clk = 1'b0;
    logic i_Rst = 1'b1;
    logic i_Data = 1'b0;
    logic o_Press, o_Release, o_Long, o_Repeat, o_Step, o_Held;

    button_event #(
        .LONG_PRESS_CYCLES (c_long),
        .REPEAT_CYCLES     (c_repeat)
    ) u_dut (
        .i_Clk     (i_Clk),
        .i_Rst     (i_Rst),
        .i_Data    (i_Data),
        .o_Press   (o_Press),
        .o_Release (o_Release),
        .o_Long    (o_Long),
        .o_Repeat  (o_Repeat),
        .o_Step    (o_Step),
        .o_Held    (o_Held)
    );

    always #5 i_Clk = ~i_Clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_press, n_release, n_long, n_repeat, n_step, n_held;

    // Reference model: tracks whether the button is armed/held and how many
    // edges have elapsed since the press was first sampled.
    bit m_locked = 1'b1;
    bit m_held   = 1'b0;
    int m_t      = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic model_edge(input bit rst, input bit d, output logic [5:0] exp_v);
        bit p, r, l, rp;
        {p, r, l, rp} = 4'b0;
        if (rst) begin
            m_locked = 1'b1;
            m_held   = 1'b0;
        end else if (m_locked) begin
            if (!d) m_locked = 1'b0;
        end else if (!m_held) begin
            if (d) begin
                m_held = 1'b1;
                m_t    = 0;
                p      = 1'b1;
            end
        end else if (!d) begin
            m_held = 1'b0;
            r      = 1'b1;
        end else begin
            m_t++;
            if (m_t == c_long) l = 1'b1;
            else if (m_t > c_long && ((m_t - c_long) % c_repeat) == 0) rp = 1'b1;
        end
        exp_v = {p, r, l, rp, (p | l | rp), m_held};
    endtask

    task automatic clear_counts();
        n_press = 0; n_release = 0; n_long = 0; n_repeat = 0; n_step = 0; n_held = 0;
    endtask

    // Drive one sample, let the edge happen, then compare on the falling edge.
    task automatic tick(input bit rst, input bit d, input string tag);
        logic [5:0] exp_v;
        i_Rst  = rst;
        i_Data = d;
        @(posedge i_Clk);
        model_edge(rst, d, exp_v);
        @(negedge i_Clk);
        check(tag, {26'b0, o_Press, o_Release, o_Long, o_Repeat, o_Step, o_Held}, {26'b0, exp_v});
        n_press   += int'(o_Press);
        n_release += int'(o_Release);
        n_long    += int'(o_Long);
        n_repeat  += int'(o_Repeat);
        n_step    += int'(o_Step);
        n_held    += int'(o_Held);
    endtask

    task automatic run(input bit rst, input bit d, input int n, input string tag);
        for (int i = 0; i < n; i++) tick(rst, d, tag);
    endtask

    initial begin
        run(1, 0, 3, "reset");
        run(0, 0, 3, "idle");

        clear_counts();
        run(0, 1, 5, "short_hold");
        run(0, 0, 3, "short_rel");
        check("short_steps", n_step, 1);
        check("short_held", n_held, 5);
        check("short_long", n_long, 0);

        clear_counts();
        run(0, 1, 20, "long_hold");
        check("long_steps", n_step, 5);
        check("long_long", n_long, 1);
        check("long_repeats", n_repeat, 3);
        run(0, 0, 3, "long_rel");

        clear_counts();
        run(0, 1, 8, "collide_hold");
        run(0, 0, 3, "collide_rel");
        check("collide_long", n_long, 0);
        check("collide_release", n_release, 1);

        clear_counts();
        run(1, 1, 2, "held_rst");
        run(0, 1, 10, "held_lock");
        run(0, 0, 3, "held_unlock");
        check("held_pulses", n_press + n_release + n_long + n_repeat, 0);
        clear_counts();
        run(0, 1, 3, "after_lock");
        run(0, 0, 2, "after_lock_rel");
        check("after_lock_press", n_press, 1);

        run(0, 1, 14, "mid_hold");
        clear_counts();
        tick(1, 1, "mid_rst");
        run(0, 1, 3, "mid_locked");
        run(0, 0, 2, "mid_unlock");
        check("mid_release", n_release, 0);
        run(0, 1, 2, "mid_repress");
        run(0, 0, 2, "mid_repress_rel");
        check("mid_repress", n_press, 1);

        clear_counts();
        for (int k = 0; k < 4; k++) begin
            tick(0, 1, "b2b_hi");
            tick(0, 0, "b2b_lo");
        end
        tick(0, 0, "b2b_tail");
        check("b2b_press", n_press, 4);
        check("b2b_release", n_release, 4);

        for (int b = 0; b < 60; b++) begin
            int len;
            len = int'($urandom_range(1, 25));
            if ($urandom_range(0, 12) == 0) run(1, 1'($urandom_range(0, 1)), 1, "rand_rst");
            run(0, 1'(b % 2), len, "rand");
        end
        run(0, 0, 3, "rand_tail");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/button_event.md
# button_event

Converts one debounced, clock-synchronous push-button level into single-cycle event pulses: press, release, long-press and auto-repeat. It sits directly downstream of the per-button debounce stage and feeds the display-control logic of the Max7219 design, for example a value counter that steps on a short press and keeps stepping while the button is held. It is instantiated once per button.

## Interface
- `LONG_PRESS_CYCLES`, default 12_000_000: hold time for a long press, in cycles (1 s at 12 MHz). Legal range ≥ 2.
- `REPEAT_CYCLES`, default 3_000_000: auto-repeat period after a long press, in cycles. Legal range ≥ 1.
- `i_Clk`  input  1  system clock; all logic is on the rising edge.
- `i_Rst`  input  1  reset, synchronous, active-high.
- `i_Data`  input  1  debounced button level, 1 = pressed. Already synchronous to `i_Clk`; no synchronizer inside this block.
- `o_Press`  output  1  one-cycle pulse on press.
- `o_Release`  output  1  one-cycle pulse on release.
- `o_Long`  output  1  one-cycle pulse, at most once per press, when the hold reaches `LONG_PRESS_CYCLES`.
- `o_Repeat`  output  1  one-cycle pulse every `REPEAT_CYCLES` after `o_Long`, while still held.
- `o_Step`  output  1  `o_Press | o_Long | o_Repeat`; the increment strobe for the consumer.
- `o_Held`  output  1  level, high while the FSM is in PRESSED or REPEAT.

## Operation
- **Outputs:** all outputs are registered. `o_Step` is built from registered terms, so it carries no extra combinational path.
- **States:** LOCK, IDLE, PRESSED, REPEAT.
- **LOCK (reset state):**
  - Wait for `i_Data` sampled 0, then go to IDLE.
  - A button already held when reset is released produces no `o_Press` and no `o_Release`.
- **IDLE:**
  - `i_Data` = 1 → PRESSED. Pulse `o_Press`, load the hold counter to 1, set `o_Held`.
- **PRESSED:**
  - `i_Data` = 0 → IDLE. Pulse `o_Release`, clear `o_Held` and the counter.
  - Counter reaches `LONG_PRESS_CYCLES` → REPEAT. Pulse `o_Long`, load the counter to 1.
  - Otherwise increment the counter.
- **REPEAT:**
  - `i_Data` = 0 → IDLE. Pulse `o_Release`.
  - Counter reaches `REPEAT_CYCLES` → pulse `o_Repeat`, reload the counter to 1, stay in REPEAT.
  - Otherwise increment the counter.
- **Counter:**
  - One shared counter of width `$clog2(max(LONG_PRESS_CYCLES, REPEAT_CYCLES) + 1)`.
  - It never exceeds its terminal value, so it never wraps.
- **Priority:** if release is sampled on the same edge that would fire `o_Long` or `o_Repeat`, release wins. Only `o_Release` pulses and the FSM goes to IDLE.
- **Mutual exclusion:** `o_Press`, `o_Release`, `o_Long` and `o_Repeat` are never high in the same cycle.
- **Reset:**
  - Asserting `i_Rst` at any edge forces LOCK, clears the counter and drives every output to 0 in the next cycle.
  - This applies mid-hold too: no `o_Release` is emitted for a press interrupted by reset.

## Timing
- Let E0 be the first edge at which `i_Data` = 1 is sampled in IDLE.
- **Press:** `o_Press` and `o_Held` go high in the cycle after E0, a latency of 1 cycle.
- **Long press:** `o_Long` is high in the cycle after edge E0 + `LONG_PRESS_CYCLES`.
- **Repeat:** `o_Repeat` is high after edge E0 + `LONG_PRESS_CYCLES` + k·`REPEAT_CYCLES`, for k ≥ 1.
- **Release:** let Er be the first edge sampling `i_Data` = 0 in PRESSED or REPEAT.
  - `o_Release` is high, and `o_Held` low, in the cycle after Er.
  - The FSM is in IDLE after Er, so a new press can be sampled at Er + 1.
- **Reset values:** `o_Press`, `o_Release`, `o_Long`, `o_Repeat`, `o_Step` and `o_Held` are all 0.
- **Minimum press:** `i_Data` high for exactly one sampled edge gives `o_Press` at E0 + 1 and `o_Release` at E0 + 2.

## Structure
- Package `button_event_pkg` holds:
  - the state enum typedef `btn_state_t` (LOCK, IDLE, PRESSED, REPEAT);
  - a function returning the counter width from the two parameters.
- Single module, no sub-module: one FSM and one counter.
- Parameter-legality assertions live in the module under simulation-only guards.

## Test plan
Bench parameters: `LONG_PRESS_CYCLES` = 8, `REPEAT_CYCLES` = 3.

- **Short press.** Stimulus: `i_Data` high 5 cycles, then low. Required response:
  - `o_Press` at E0 + 1 and `o_Release` at E0 + 6;
  - no `o_Long`;
  - `o_Step` exactly once;
  - `o_Held` high for 5 cycles.
- **Long hold.** Stimulus: `i_Data` high 20 cycles. Required response:
  - `o_Long` at E0 + 9;
  - `o_Repeat` at E0 + 12, E0 + 15, E0 + 18;
  - `o_Step` count = 5 before release.
- **Release collides with long press.** Stimulus: first low sample exactly at edge E0 + 8. Required response: `o_Release` at E0 + 9, no `o_Long`.
- **Button held through reset.** Stimulus: `i_Rst` deasserted with `i_Data` = 1, held 10 cycles, then released. Required response: no pulses at all. The next press afterwards gives a normal `o_Press`.
- **Reset mid-hold.** Stimulus: `i_Rst` asserted during REPEAT. Required response: all outputs 0 the next cycle and no `o_Release`. The FSM returns to IDLE only after `i_Data` goes low.
- **Back-to-back presses.** Stimulus: presses 1 cycle high / 1 cycle low, ×4. Required response: four `o_Press`/`o_Release` pairs, never overlapping.
